// File: rtl/spi_pkg.sv
// Shared SPI definitions: command word type and default TX FIFO sizing.
package spi_pkg;

  localparam int unsigned SPI_WORD_W        = 65;
  localparam int unsigned SPI_TX_FIFO_DEPTH = 16;

  typedef logic [SPI_WORD_W-1:0] spi_word_t;

endpackage

// File: rtl/spi_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port, no reset.
module spi_fifo_mem #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/spi_tx_fifo.sv
// First-word-fall-through transmit buffer feeding the SPI master FIFO-TX port.
// Pointers, occupancy, sticky error flags and the registered head word live here.
module spi_tx_fifo
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH = SPI_WORD_W,
  parameter int unsigned DEPTH = SPI_TX_FIFO_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] D_push,
  output logic             full,
  output logic             pndgn,
  output logic [WIDTH-1:0] D_pop,
  input  logic             pop,
  output logic [AW:0]      count,
  input  logic             clr_err,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [AW:0]      count_next;
  logic [AW:0]      remain;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] dpop_next;
  logic             push_ok;
  logic             pop_ok;
  logic             drop;
  logic             starve;

  spi_fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (push_ok),
    .waddr(wr_ptr),
    .wdata(D_push),
    .raddr(rd_next),
    .rdata(rdata)
  );

  always_comb begin
    pop_ok  = pop && (count != '0);
    push_ok = push && ((count != FULL_CNT) || pop);
    drop    = push && (count == FULL_CNT) && !pop;
    starve  = pop && (count == '0);
    rd_next = pop_ok ? rd_ptr + AW'(1) : rd_ptr;
    remain  = count - (AW+1)'(pop_ok);

    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase

    // If no older word survives this edge, the head is the word being written now;
    // it is not yet readable from the array, so load it from the write data.
    dpop_next = D_pop;
    if (remain == '0) begin
      if (push_ok) dpop_next = D_push;
    end else begin
      dpop_next = rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      pndgn     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      D_pop     <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr    <= rd_next;
      count     <= count_next;
      full      <= (count_next == FULL_CNT);
      pndgn     <= (count_next != '0);
      D_pop     <= dpop_next;
      overflow  <= drop   || (overflow  && !clr_err);
      underflow <= starve || (underflow && !clr_err);
    end
  end

endmodule

// File: tb/tb_spi_tx_fifo.sv
// Scoreboard bench for spi_tx_fifo: a queue model predicts each post-edge state, a monitor compares.
`timescale 1ns/1ps
module tb_spi_tx_fifo;
  import spi_pkg::*;

  localparam int unsigned DEPTH = SPI_TX_FIFO_DEPTH;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef struct {
    logic [AW:0] count;
    logic        full;
    logic        pndgn;
    logic        ovf;
    logic        unf;
    spi_word_t   dpop;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        push;
  spi_word_t   D_push;
  logic        full;
  logic        pndgn;
  spi_word_t   D_pop;
  logic        pop;
  logic [AW:0] count;
  logic        clr_err;
  logic        overflow;
  logic        underflow;

  exp_t        exp_q[$];
  spi_word_t   model_q[$];
  logic        m_ovf;
  logic        m_unf;
  spi_word_t   m_last;
  int          total;
  int          bad;
  int unsigned accepted_push;

  spi_tx_fifo #(
    .WIDTH(SPI_WORD_W),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .D_push   (D_push),
    .full     (full),
    .pndgn    (pndgn),
    .D_pop    (D_pop),
    .pop      (pop),
    .count    (count),
    .clr_err  (clr_err),
    .overflow (overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_last = '0;
  endtask

  function automatic spi_word_t rand_word();
    spi_word_t w;
    w = {1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom)};
    return w;
  endfunction

  // Drive one cycle of inputs at the falling edge and predict the state after the next rising edge.
  task automatic step(input bit p, input spi_word_t d, input bit q, input bit c);
    int   n;
    bit   pop_ok, push_ok, err_o, err_u;
    exp_t e;
    @(negedge clk);
    push = p; D_push = d; pop = q; clr_err = c;
    n       = model_q.size();
    pop_ok  = q && (n > 0);
    push_ok = p && ((n < int'(DEPTH)) || q);
    err_o   = p && (n == int'(DEPTH)) && !q;
    err_u   = q && (n == 0);
    if (pop_ok) void'(model_q.pop_front());
    if (push_ok) begin
      model_q.push_back(d);
      accepted_push++;
    end
    m_ovf = err_o || (m_ovf && !c);
    m_unf = err_u || (m_unf && !c);
    if (model_q.size() > 0) m_last = model_q[0];
    e.count = (AW+1)'(model_q.size());
    e.full  = (model_q.size() == DEPTH);
    e.pndgn = (model_q.size() != 0);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    e.dpop  = m_last;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("count",     count,     e.count);
      check("full",      full,      e.full);
      check("pndgn",     pndgn,     e.pndgn);
      check("D_pop",     D_pop,     e.dpop);
      check("overflow",  overflow,  e.ovf);
      check("underflow", underflow, e.unf);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int pp;
    total = 0; bad = 0; accepted_push = 0;
    reset = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; D_push = '0;
    model_reset();
    #1;
    check("rst_count", count, 0);
    check("rst_pndgn", pndgn, 0);
    check("rst_full",  full,  0);
    check("rst_D_pop", D_pop, 0);
    check("rst_flags", {overflow, underflow}, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // single word fall-through then pop
    step(1'b1, 65'h1_0000_0000_0000_00A5, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    idle();

    // fill, overflow attempt, drain
    for (int i = 0; i < 16; i++) step(1'b1, spi_word_t'(i), 1'b0, 1'b0);
    step(1'b1, spi_word_t'(99), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);

    // full with simultaneous push and pop
    for (int i = 0; i < 16; i++) step(1'b1, spi_word_t'(i), 1'b0, 1'b0);
    step(1'b1, spi_word_t'(20), 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0);

    // underflow, pop+push on empty, clear; then set-wins-over-clear
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, spi_word_t'(7), 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    // asynchronous reset mid-cycle with words pending
    for (int i = 0; i < 5; i++) step(1'b1, rand_word(), 1'b0, 1'b0);
    idle();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_pndgn", pndgn, 0);
    check("async_count", count, 0);
    check("async_full",  full,  0);
    model_reset();
    #1 reset = 1'b0;
    step(1'b1, spi_word_t'(42), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // randomized traffic with drifting push/pop bias
    pp = 50;
    for (int i = 0; i < 10000; i++) begin
      if (i % 200 == 0) pp = $urandom_range(15, 85);
      step(($urandom_range(0, 99) < pp), rand_word(),
           ($urandom_range(0, 99) < (100 - pp)), ($urandom_range(0, 31) == 0));
    end
    idle();
    @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    check("pointer_wraps", (accepted_push >= 3 * DEPTH), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
